// File: rtl/gc_dram_retention_model.sv
// gc_dram_retention_model
//   Behavioural model of a gain-cell DRAM macro with one read, one write and
//   one refresh port. Every row carries its own retention counter. A row that
//   is not written or refreshed for RETENTION cycles dies. Reads of a dead row
//   return poison and raise rd_err. Refreshing a dead row raises ref_err.
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   re, raddr           read request; rd / rd_valid / rd_err one edge later
//   we, waddr, in       write request; reloads the row's retention counter
//   ref_en, ref_addr    refresh request; ref_err one edge later on dead/illegal row
//   alive               per-row liveness, combinational from the counters
module gc_dram_retention_model #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 128,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int RETENTION = 5000,
    parameter int CNT_W     = $clog2(RETENTION + 1),
    parameter bit POISON_X  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] in,
    input  logic              ref_en,
    input  logic [ADDR_W-1:0] ref_addr,
    output logic              ref_err,
    output logic [DEPTH-1:0]  alive
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  RET_L   = CNT_W'(RETENTION);
    localparam logic [DATA_W-1:0] POISON  = POISON_X ? {DATA_W{1'bx}} : '0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt [DEPTH];

    // Address legality (DEPTH need not be a power of two).
    logic w_legal, r_legal, f_legal;
    assign w_legal = {1'b0, waddr}    < DEPTH_L;
    assign r_legal = {1'b0, raddr}    < DEPTH_L;
    assign f_legal = {1'b0, ref_addr} < DEPTH_L;

    // Illegal addresses are steered to row 0 so no array is ever indexed out
    // of range; every use is qualified by the matching *_legal term.
    logic [ADDR_W-1:0] w_idx, r_idx, f_idx;
    assign w_idx = w_legal ? waddr    : '0;
    assign r_idx = r_legal ? raddr    : '0;
    assign f_idx = f_legal ? ref_addr : '0;

    logic r_live, f_live;
    assign r_live = r_legal && (cnt[r_idx] != '0);
    assign f_live = f_legal && (cnt[f_idx] != '0);

    // Reset overrides a write at the same edge.
    logic w_ok, f_ok, rd_ok;
    assign w_ok  = rst_n && we && w_legal;
    assign f_ok  = ref_en && f_live;
    // A read colliding with a write to the same row always fails.
    assign rd_ok = r_live && !(we && (waddr == raddr));

    logic [DEPTH-1:0] reload;

    // NOTE: give every combinationally assigned signal a default first, so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        reload = '0;
        if (w_ok) reload[w_idx] = 1'b1;
        if (f_ok) reload[f_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reload[i])
                    cnt[i] <= RET_L;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; liveness lives in the counters,
    // so clearing the data would only add a wide reset network.
    always_ff @(posedge clk) begin
        if (w_ok) mem[w_idx] <= in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd       <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            ref_err  <= 1'b0;
        end else begin
            ref_err <= ref_en && !f_live;
            if (re) begin
                if (rd_ok) begin
                    rd       <= mem[r_idx];
                    rd_valid <= 1'b1;
                    rd_err   <= 1'b0;
                end else begin
                    rd       <= POISON;
                    rd_valid <= 1'b0;
                    rd_err   <= 1'b1;
                end
            end else begin
                rd_valid <= 1'b0;
                rd_err   <= 1'b0;
            end
        end
    end

    always_comb begin
        alive = '0;
        for (int i = 0; i < DEPTH; i++) alive[i] = (cnt[i] != '0);
    end

endmodule

// File: tb/tb_gc_dram_retention_model.sv
// Testbench for gc_dram_retention_model.
//   dut_a: DEPTH=100, RETENTION=5000, zero poison; directed table + long
//          retention-window sequences.
//   dut_b: DEPTH=6, RETENTION=8, zero poison; random traffic against a
//          deadline-based reference model.
module tb_gc_dram_retention_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint edge_n = 0;

    // ---------------- dut_a ----------------
    localparam int A_RET = 5000;
    logic        a_rst_n, a_re, a_we, a_ref_en;
    logic [6:0]  a_raddr, a_waddr, a_ref_addr;
    logic [63:0] a_in, a_rd;
    logic        a_rd_valid, a_rd_err, a_ref_err;
    logic [99:0] a_alive;

    gc_dram_retention_model #(
        .DATA_W(64), .DEPTH(100), .ADDR_W(7), .RETENTION(A_RET), .CNT_W(13), .POISON_X(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .re(a_re), .raddr(a_raddr), .rd(a_rd),
        .rd_valid(a_rd_valid), .rd_err(a_rd_err), .we(a_we), .waddr(a_waddr),
        .in(a_in), .ref_en(a_ref_en), .ref_addr(a_ref_addr), .ref_err(a_ref_err),
        .alive(a_alive)
    );

    // ---------------- dut_b ----------------
    localparam int B_RET = 8;
    localparam int B_DEPTH = 6;
    logic       b_rst_n, b_re, b_we, b_ref_en;
    logic [2:0] b_raddr, b_waddr, b_ref_addr;
    logic [7:0] b_in, b_rd;
    logic       b_rd_valid, b_rd_err, b_ref_err;
    logic [5:0] b_alive;

    gc_dram_retention_model #(
        .DATA_W(8), .DEPTH(B_DEPTH), .ADDR_W(3), .RETENTION(B_RET), .CNT_W(4), .POISON_X(1'b0)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .re(b_re), .raddr(b_raddr), .rd(b_rd),
        .rd_valid(b_rd_valid), .rd_err(b_rd_err), .we(b_we), .waddr(b_waddr),
        .in(b_in), .ref_en(b_ref_en), .ref_addr(b_ref_addr), .ref_err(b_ref_err),
        .alive(b_alive)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic a_idle();
        a_we = 1'b0; a_re = 1'b0; a_ref_en = 1'b0;
    endtask

    // Idle dut_a until edge t has completed.
    task automatic a_idle_to(input longint t);
        a_idle();
        while (edge_n < t) tick();
    endtask

    typedef struct {
        logic        we;
        logic [6:0]  waddr;
        logic [63:0] din;
        logic        re;
        logic [6:0]  raddr;
        logic        ref_en;
        logic [6:0]  ref_addr;
        logic [63:0] exp_rd;
        logic        exp_valid;
        logic        exp_err;
        logic        exp_ref_err;
    } vec_t;

    vec_t vecs [12];

    // Random-phase reference model: each row is alive at edge e (pre-edge)
    // while e <= deadline; a write/refresh at edge e sets deadline = e+RETENTION.
    longint     dl [B_DEPTH];
    logic [7:0] mm [B_DEPTH];

    function automatic bit b_live(input int r, input longint e);
        return (r < B_DEPTH) && (dl[r] >= e);
    endfunction

    initial begin
        longint     e0, e;
        logic [7:0] exp_rd;
        logic       exp_v, exp_e, exp_f;
        logic [5:0] exp_alive;
        int         wa, ra, fa;

        a_rst_n = 1'b0; a_idle(); a_waddr = '0; a_raddr = '0; a_ref_addr = '0; a_in = '0;
        b_rst_n = 1'b0; b_we = 1'b0; b_re = 1'b0; b_ref_en = 1'b0;
        b_waddr = '0; b_raddr = '0; b_ref_addr = '0; b_in = '0;

        vecs[0]  = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd5,   1'b0, 7'd0,   64'h0,         1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 7'd3,   64'hDEAD_BEEF, 1'b0, 7'd0,   1'b0, 7'd0,   64'h0,         1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd3,   1'b0, 7'd0,   64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 7'd10,  64'h1,         1'b1, 7'd10,  1'b0, 7'd0,   64'h0,         1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd10,  1'b0, 7'd0,   64'h1,         1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 7'd100, 64'h55,        1'b1, 7'd3,   1'b0, 7'd0,   64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd100, 1'b0, 7'd0,   64'h0,         1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd120, 1'b1, 7'd127, 64'h0,         1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 7'd0,   64'h0,         1'b0, 7'd0,   1'b1, 7'd8,   64'h0,         1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 7'd11,  64'hAB,        1'b1, 7'd3,   1'b1, 7'd3,   64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 7'd0,   64'h0,         1'b1, 7'd11,  1'b0, 7'd0,   64'hAB,        1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 7'd0,   64'h0,         1'b0, 7'd0,   1'b0, 7'd0,   64'hAB,        1'b0, 1'b0, 1'b0};

        // ---- reset state ----
        tick(); tick();
        check("rst alive", a_alive, '0);
        check("rst rd", a_rd, 64'h0);
        check("rst rd_valid", a_rd_valid, 1'b0);
        check("rst rd_err", a_rd_err, 1'b0);
        check("rst ref_err", a_ref_err, 1'b0);
        a_rst_n = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < 12; i++) begin
            a_we = vecs[i].we; a_waddr = vecs[i].waddr; a_in = vecs[i].din;
            a_re = vecs[i].re; a_raddr = vecs[i].raddr;
            a_ref_en = vecs[i].ref_en; a_ref_addr = vecs[i].ref_addr;
            tick();
            check($sformatf("vec%0d rd", i), a_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d rd_valid", i), a_rd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d rd_err", i), a_rd_err, vecs[i].exp_err);
            check($sformatf("vec%0d ref_err", i), a_ref_err, vecs[i].exp_ref_err);
        end
        a_idle();
        check("table alive", a_alive, (128'd1 << 3) | (128'd1 << 10) | (128'd1 << 11));

        // ---- retention window: write row 3 at E0 ----
        a_we = 1'b1; a_waddr = 7'd3; a_in = 64'hDEAD_BEEF;
        tick(); e0 = edge_n; a_idle();
        a_re = 1'b1; a_raddr = 7'd3; tick();
        check("win first rd", a_rd, 64'hDEAD_BEEF);
        check("win first valid", a_rd_valid, 1'b1);
        a_idle_to(e0 + A_RET - 1);
        check("win alive before", a_alive[3], 1'b1);
        a_re = 1'b1; a_raddr = 7'd3; tick();
        check("win last valid", a_rd_valid, 1'b1);
        check("win last rd", a_rd, 64'hDEAD_BEEF);
        check("win alive fell", a_alive[3], 1'b0);
        tick();
        check("win expired err", a_rd_err, 1'b1);
        check("win expired valid", a_rd_valid, 1'b0);
        check("win expired rd", a_rd, 64'h0);

        // ---- refresh extends row 7 ----
        a_idle(); a_we = 1'b1; a_waddr = 7'd7; a_in = 64'h7777;
        tick(); e0 = edge_n;
        a_idle_to(e0 + 3999);
        a_ref_en = 1'b1; a_ref_addr = 7'd7; tick();
        check("ref live ref_err", a_ref_err, 1'b0);
        a_idle_to(e0 + 8999);
        a_re = 1'b1; a_raddr = 7'd7; tick();
        check("ref last valid", a_rd_valid, 1'b1);
        check("ref last rd", a_rd, 64'h7777);
        tick();
        check("ref expired err", a_rd_err, 1'b1);
        a_idle(); a_ref_en = 1'b1; a_ref_addr = 7'd8; tick();
        check("ref unwritten", a_ref_err, 1'b1);
        a_ref_addr = 7'd7; tick();
        check("ref dead row", a_ref_err, 1'b1);
        a_idle(); a_re = 1'b1; a_raddr = 7'd7; tick();
        check("ref no revive", a_rd_err, 1'b1);
        a_idle(); tick();
        check("ref_err clears", a_ref_err, 1'b0);

        // ---- reset mid-window kills all rows ----
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_waddr = 7'(i); a_in = 64'(i + 1); tick();
        end
        a_idle(); a_re = 1'b1; a_raddr = 7'd2; tick();
        a_idle_to(edge_n + 100);
        check("fill alive", a_alive[3:0], 4'hF);
        check("fill rd", a_rd, 64'h3);
        a_rst_n = 1'b0; a_we = 1'b1; a_waddr = 7'd5; tick();
        a_idle(); a_rst_n = 1'b1;
        check("midrst alive", a_alive, '0);
        check("midrst rd", a_rd, 64'h0);
        for (int i = 0; i < 4; i++) begin
            a_re = 1'b1; a_raddr = 7'(i); tick();
            check($sformatf("midrst row%0d err", i), a_rd_err, 1'b1);
        end
        a_idle();

        // ---- random traffic on dut_b ----
        exp_rd = '0;
        for (int r = 0; r < B_DEPTH; r++) begin dl[r] = 0; mm[r] = '0; end
        for (int c = 0; c < 3000; c++) begin
            b_rst_n    = !((c == 0) || ($urandom_range(0, 199) == 0));
            b_we       = ($urandom_range(0, 3) == 0);
            b_waddr    = 3'($urandom_range(0, 7));
            b_in       = 8'($urandom);
            b_re       = 1'($urandom_range(0, 1));
            b_raddr    = 3'($urandom_range(0, 7));
            b_ref_en   = ($urandom_range(0, 2) == 0);
            b_ref_addr = 3'($urandom_range(0, 7));
            wa = int'(b_waddr); ra = int'(b_raddr); fa = int'(b_ref_addr);
            e = edge_n + 1;

            if (!b_rst_n) begin
                for (int r = 0; r < B_DEPTH; r++) dl[r] = 0;
                exp_rd = '0; exp_v = 1'b0; exp_e = 1'b0; exp_f = 1'b0;
            end else begin
                exp_f = b_ref_en && !b_live(fa, e);
                exp_v = 1'b0; exp_e = 1'b0;
                if (b_re) begin
                    if (b_live(ra, e) && !(b_we && wa == ra)) begin
                        exp_rd = mm[ra]; exp_v = 1'b1;
                    end else begin
                        exp_rd = '0; exp_e = 1'b1;
                    end
                end
                if (b_ref_en && b_live(fa, e)) dl[fa] = e + B_RET;
                if (b_we && wa < B_DEPTH) begin
                    mm[wa] = b_in; dl[wa] = e + B_RET;
                end
            end
            for (int r = 0; r < B_DEPTH; r++) exp_alive[r] = (dl[r] >= e + 1);

            tick();
            check("rnd rd", b_rd, exp_rd);
            check("rnd rd_valid", b_rd_valid, exp_v);
            check("rnd rd_err", b_rd_err, exp_e);
            check("rnd ref_err", b_ref_err, exp_f);
            check("rnd alive", b_alive, exp_alive);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
